// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared constants, FSM state type and framebuffer address helper for the RAM arbiter.
package mcpu_pkg;
  localparam int ADDR_BITS = 12;
  localparam int ROW_BITS = 7;
  localparam int WORDS_PER_LINE = 16;
  localparam int IDX_BITS = $clog2(WORDS_PER_LINE);
  localparam logic [ADDR_BITS-1:0] FB_BASE = 12'h800;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  function automatic logic [ADDR_BITS-1:0] fb_addr(input logic [ROW_BITS-1:0] row, input logic [IDX_BITS-1:0] idx);
    logic [ROW_BITS+IDX_BITS-1:0] off;
    off = {row, idx};
    return FB_BASE + ADDR_BITS'(off);
  endfunction
endpackage

// File: rtl/mcpu_line_buffer.sv
// mcpu_line_buffer: two-bank scanline store, one write port and one registered read port.
module mcpu_line_buffer
  import mcpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                wr_bank,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [31:0]         wr_data,
  input  logic                rd_bank,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [31:0]         rd_data
);
  logic [31:0] mem [2*WORDS_PER_LINE];
  always_ff @(posedge clk)
    if (we) mem[{wr_bank, wr_idx}] <= wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rd_data <= '0;
    else rd_data <= mem[{rd_bank, rd_idx}];
endmodule

// File: rtl/mcpu_ram_arbiter.sv
// mcpu_ram_arbiter: shares the work RAM between the CPU (absolute priority) and a scanline prefetcher.
module mcpu_ram_arbiter
  import mcpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ack,
  input  logic                 line_start,
  input  logic [ROW_BITS-1:0]  line_row,
  input  logic [IDX_BITS-1:0]  pix_idx,
  output logic [31:0]          pix_word,
  input  logic                 clr_underrun,
  output logic                 underrun,
  output logic                 fetch_busy,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata
);
  state_t state, state_n;
  logic [IDX_BITS-1:0] cnt, pidx;
  logic [ROW_BITS-1:0] row;
  logic bank_sel, pv, rd_pend, issue, last;
  logic [31:0] rd_hold;
  assign issue = (state == FETCH) && !cpu_req;
  assign last = cnt == IDX_BITS'(WORDS_PER_LINE - 1);
  assign ram_addr = cpu_req ? cpu_addr : (state == FETCH) ? fb_addr(row, cnt) : '0;
  assign ram_we = cpu_req & cpu_we;
  assign ram_wdata = cpu_wdata;
  // read data comes straight from the RAM in the ack cycle; writes leave the last read visible
  assign cpu_rdata = rd_pend ? ram_rdata : rd_hold;
  always_comb
    state_n = line_start ? FETCH : (issue && last) ? DRAIN : (state == DRAIN) ? IDLE : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      pidx <= '0;
      row <= '0;
      bank_sel <= 1'b0;
      pv <= 1'b0;
      rd_pend <= 1'b0;
      rd_hold <= '0;
      cpu_ack <= 1'b0;
      underrun <= 1'b0;
      fetch_busy <= 1'b0;
    end else begin
      state <= state_n;
      fetch_busy <= state_n != IDLE;
      cpu_ack <= cpu_req;
      rd_pend <= cpu_req & ~cpu_we;
      rd_hold <= cpu_rdata;
      pv <= issue & ~line_start;
      pidx <= cnt;
      cnt <= line_start ? '0 : issue ? cnt + IDX_BITS'(1) : cnt;
      underrun <= (line_start && state != IDLE) | (underrun & ~clr_underrun);
      if (line_start) begin
        bank_sel <= ~bank_sel;
        row <= line_row;
      end
    end
  // a writeback still in flight when the banks swap belongs to the old line and is dropped
  mcpu_line_buffer u_lb (
    .clk(clk),
    .reset(reset),
    .we(pv & ~line_start),
    .wr_bank(~bank_sel),
    .wr_idx(pidx),
    .wr_data(ram_rdata),
    .rd_bank(bank_sel),
    .rd_idx(pix_idx),
    .rd_data(pix_word)
  );
endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// tb_mcpu_ram_arbiter: directed scenarios with a scoreboard on CPU acks and direct checks on scanout/fetch.
module tb_mcpu_ram_arbiter;
  import mcpu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_BITS-1:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0, cpu_rdata;
  logic cpu_ack;
  logic line_start = 1'b0;
  logic [ROW_BITS-1:0] line_row = '0;
  logic [IDX_BITS-1:0] pix_idx = '0;
  logic [31:0] pix_word;
  logic clr_underrun = 1'b0, underrun, fetch_busy;
  logic [ADDR_BITS-1:0] ram_addr;
  logic ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] ram [4096];
  logic [31:0] exp_q [$];
  logic [ADDR_BITS-1:0] addr_log [$];
  logic [31:0] last_rd = '0;
  int n_cmp = 0, n_err = 0;
  int n;

  always #5 clk = ~clk;

  mcpu_ram_arbiter dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .line_start(line_start),
    .line_row(line_row), .pix_idx(pix_idx), .pix_word(pix_word), .clr_underrun(clr_underrun),
    .underrun(underrun), .fetch_busy(fetch_busy), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_val(input logic [ADDR_BITS-1:0] a);
    if (a >= 12'h850 && a <= 12'h85F) return 32'hA000_0000 + 32'(a - 12'h850);
    if (a >= 12'hFF0) return 32'hB000_0000 + 32'(a[3:0]);
    return 32'hDEAD_0000 | 32'(a);
  endfunction

  initial for (int i = 0; i < 4096; i++) ram[i] = init_val(ADDR_BITS'(i));

  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    if (ram_we) ram[ram_addr] = ram_wdata;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset && cpu_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL cpu_ack_unexpected: got ack with rdata %h expected no ack", cpu_rdata);
      end else check("cpu_rdata", cpu_rdata, exp_q.pop_front());
    end

  always @(negedge clk)
    if (reset && !cpu_req && ram_addr != '0) addr_log.push_back(ram_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd(input logic [ADDR_BITS-1:0] a);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = a;
    last_rd = init_val(a);
    exp_q.push_back(last_rd);
  endtask

  task automatic do_line_start(input logic [ROW_BITS-1:0] r);
    line_start = 1'b1;
    line_row = r;
    step();
    line_start = 1'b0;
  endtask

  task automatic run_busy(input bit cpu_alt, output int cnt);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (cpu_alt && c % 2 == 0) cpu_rd(ADDR_BITS'(12'h100 + c));
      else cpu_req = 1'b0;
      @(negedge clk);
      if (!fetch_busy) break;
      cnt++;
      step();
    end
    step();
    cpu_req = 1'b0;
  endtask

  task automatic check_front(input logic [31:0] base);
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      pix_idx = IDX_BITS'(i);
      step();
      @(negedge clk);
      check("pix_word", pix_word, base + 32'(i));
    end
  endtask

  task automatic check_log(input logic [ADDR_BITS-1:0] base);
    check("fetch_count", 32'(addr_log.size()), 32'(WORDS_PER_LINE));
    for (int i = 0; i < WORDS_PER_LINE; i++)
      check("fetch_addr", i < addr_log.size() ? 32'(addr_log[i]) : 32'hFFFF_FFFF, 32'(base + ADDR_BITS'(i)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_pix_word", pix_word, 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_fetch_busy", 32'(fetch_busy), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    reset = 1'b1;
    step();
    addr_log.delete();
    do_line_start(5);
    run_busy(0, n);
    check("busy_idle_cpu", n, 17);
    check("underrun_clean", 32'(underrun), 0);
    check_log(12'h850);
    do_line_start(6);
    check_front(32'hA000_0000);
    run_busy(0, n);
    check("underrun_clean2", 32'(underrun), 0);
    do_line_start(5);
    run_busy(1, n);
    check("busy_cpu_alt", n, 33);
    do_line_start(0);
    check_front(32'hA000_0000);
    run_busy(0, n);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 12'h850;
    cpu_wdata = 32'h1234_5678;
    exp_q.push_back(last_rd);
    @(negedge clk);
    check("ram_we_write", 32'(ram_we), 1);
    step();
    cpu_we = 1'b0;
    last_rd = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    check("ram_we_read", 32'(ram_we), 0);
    step();
    cpu_req = 1'b0;
    repeat (2) step();
    check("sb_drained_wr", 32'(exp_q.size()), 0);
    do_line_start(2);
    repeat (7) step();
    do_line_start(3);
    addr_log.delete();
    @(negedge clk);
    check("underrun_set", 32'(underrun), 1);
    step();
    check("restart_addr", addr_log.size() > 0 ? 32'(addr_log[0]) : 32'hFFFF_FFFF, 32'h830);
    run_busy(0, n);
    check("underrun_sticky", 32'(underrun), 1);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    @(negedge clk);
    check("underrun_clr", 32'(underrun), 0);
    step();
    addr_log.delete();
    do_line_start(127);
    run_busy(0, n);
    check_log(12'hFF0);
    do_line_start(127);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cpu_rd(ADDR_BITS'(12'h200 + k));
      @(negedge clk);
      if (fetch_busy) n++;
      step();
    end
    check("busy_cpu_hold", n, 100);
    run_busy(0, n);
    check("busy_after_hold", n, 17);
    repeat (2) step();
    check("sb_drained", 32'(exp_q.size()), 0);
    do_line_start(5);
    repeat (3) step();
    do_line_start(5);
    repeat (7) step();
    #2 reset = 1'b0;
    #1;
    check("arst_fetch_busy", 32'(fetch_busy), 0);
    check("arst_underrun", 32'(underrun), 0);
    check("arst_cpu_ack", 32'(cpu_ack), 0);
    check("arst_cpu_rdata", cpu_rdata, 0);
    check("arst_pix_word", pix_word, 0);
    check("arst_ram_addr", 32'(ram_addr), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    addr_log.delete();
    repeat (20) step();
    check("post_rst_no_fetch", 32'(addr_log.size()), 0);
    check("post_rst_idle", 32'(fetch_busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mcpu_ram_arbiter.md
Name: mcpu_ram_arbiter

Overview:
- Sole owner of the 32-bit single-port framebuffer/work RAM.
- Shares the RAM between the MCPU core load/store port and a video line prefetcher.
- Once per scanline, copies one framebuffer row (16 words = 128 4-bit pixels) into a double-buffered line buffer in cycles the CPU leaves idle.
- The pixel mux reads the front bank, so scanout never contends with the CPU for RAM.

Parameters:
- ADDR_BITS, 12, RAM word-address width.
- ROW_BITS, 7, framebuffer row-index width.
- WORDS_PER_LINE, 16, words fetched per row (power of two, index width IDX_BITS = log2).
- FB_BASE, 12'h800, word address of framebuffer row 0.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, one access per cycle while high.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_BITS  CPU word address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  access completed (read data valid).
- line_start  in  1  one-cycle pulse: swap banks, begin fetching line_row.
- line_row  in  ROW_BITS  row to fetch, sampled with line_start.
- pix_idx  in  IDX_BITS  front-bank word index for scanout.
- pix_word  out  32  front-bank word, registered.
- clr_underrun  in  1  clears the underrun flag.
- underrun  out  1  sticky: a fetch was cut short by line_start.
- fetch_busy  out  1  high in FETCH or DRAIN.
- ram_addr  out  ADDR_BITS  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, one-cycle synchronous latency.

Behaviour:
- Reset (async, reset low): state IDLE; counter 0; bank select 0; cpu_ack, cpu_rdata, pix_word, underrun, fetch_busy, fetch-pipeline valid all 0. Line-buffer contents are not reset.
- RAM mux is combinational. cpu_req=1 → ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
- Otherwise in FETCH: ram_addr = FB_BASE + {row, cnt}, truncated to ADDR_BITS; ram_we=0.
- Otherwise: ram_addr=0, ram_we=0.
- CPU has absolute priority and is never stalled. cpu_ack=1 exactly one cycle after each cycle with cpu_req=1.
- For reads, cpu_rdata = ram_rdata in the ack cycle. For writes, cpu_rdata holds its previous value.
- FSM: IDLE, FETCH, DRAIN.
  - line_start in any state: toggle bank select (back becomes front), latch row, cnt=0 → FETCH.
  - FETCH: each cycle with cpu_req=0, issue a read of word cnt; record (valid, idx) in a one-stage pipeline; cnt++. Issuing word WORDS_PER_LINE-1 → DRAIN.
  - DRAIN: one cycle for the last writeback → IDLE.
- Writeback: in the cycle after an issue, back[idx] ← ram_rdata.
- A writeback pending in a line_start cycle is discarded. It must never land in the new front bank.
- line_start while state ≠ IDLE sets underrun=1. The partially filled bank is still swapped and the new fetch starts.
- Underrun clears only on clr_underrun=1 (line_start has priority if both occur).
- pix_word ← front[pix_idx] every cycle, one-cycle latency. On a swap, the read in the following cycle reflects the new front bank.
- fetch_busy = (state==FETCH || state==DRAIN), registered with state.
- Minimum fetch time is WORDS_PER_LINE+1 cycles with an idle CPU. Each CPU access cycle adds one cycle.

Decomposition:
- Package mcpu_pkg:
  - Constants: ADDR_BITS, ROW_BITS, WORDS_PER_LINE, FB_BASE.
  - State enum: IDLE/FETCH/DRAIN.
  - Helper function: fb_addr(row, idx).
- Sub-module mcpu_line_buffer:
  - 2 banks × WORDS_PER_LINE × 32.
  - One write port (bank, idx, data, we).
  - One registered read port (bank, idx).
  - No reset on storage.

Test Plan:
- Idle CPU, RAM[0x800+16*5+i]=0xA000_0000+i, line_start with line_row=5 → fetch_busy high for 17 cycles, underrun 0. After the next line_start, pix_idx=3 gives pix_word=0xA000_0003 one cycle later.
- cpu_req=1 every other cycle during a row-5 fetch → every CPU access acked next cycle with correct data; fetch completes in 33 cycles; all 16 words correct.
- CPU write 0x1234_5678 to 0x850, then read 0x850 → second ack carries 0x1234_5678; ram_we high only in the write cycle.
- line_start 8 cycles after the previous one → underrun=1 and stays 1. New fetch starts at word 0; clr_underrun → underrun=0.
- line_row=127 → addresses 0xFF0..0xFFF issued, no wrap past ADDR_BITS. cpu_req held high 100 cycles → no fetch issues, fetch_busy stays 1.
- reset asserted mid-FETCH (cnt=7) → all outputs 0 immediately, state IDLE. After release, no RAM fetch issued until line_start.
